// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Multi-cycle control sequencer for an RV32I-subset datapath.
//               Accepts one instruction over valid/ready, walks it through
//               DECODE/EXEC/MEM/WB and drives register addresses, ALUOp,
//               immediate, register-file, memory and mux controls.
//               Optional feature macro: BRANCH_EN (adds BEQ/BNE and the
//               branch_taken output).
// Ports       : clk, reset (sync, active-high)
//               instr_valid/instr/instr_ready : instruction handshake
//               zero_flag                     : ALU zero (branch resolve)
//               reg1/reg2/write_reg_addr      : rs1/rs2/rd of latched instr
//               alu_op, alu_src_imm, imm_out  : ALU controls
//               reg_we, mem_re, mem_we, mem_to_reg : datapath enables
//               done, illegal                 : per-instruction pulses
//               branch_taken (BRANCH_EN only) : EXEC-cycle branch decision
//               retired_cnt                   : wrapping completion count
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 3,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [31:0]        instr,
    output logic               instr_ready,
    input  logic               zero_flag,
    output logic [RADDR_W-1:0] reg1_addr,
    output logic [RADDR_W-1:0] reg2_addr,
    output logic [RADDR_W-1:0] write_reg_addr,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_src_imm,
    output logic [XLEN-1:0]    imm_out,
    output logic               reg_we,
    output logic               mem_re,
    output logic               mem_we,
    output logic               mem_to_reg,
    output logic               done,
    output logic               illegal,
`ifdef BRANCH_EN
    output logic               branch_taken,
`endif
    output logic [CNT_W-1:0]   retired_cnt
);

    localparam int c_LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_LAT_W-1:0] c_MEM_LAST = c_LAT_W'(MEM_LAT - 1);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
`ifdef BRANCH_EN
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
`endif

    localparam logic [ALUOP_W-1:0] c_ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] c_ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] c_ALU_AND = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] c_ALU_OR  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] c_ALU_XOR = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] c_ALU_SLT = ALUOP_W'(5);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t               r_state;
    logic [31:0]          r_ir;
    logic [c_LAT_W-1:0]   r_mem_cnt;
    logic                 r_legal;
    logic                 r_load;
    logic                 r_store;
    logic                 r_branch;

    state_t               w_nxt_state;
    logic [31:0]          w_nxt_ir;
    logic [c_LAT_W-1:0]   w_nxt_mem_cnt;

    // Decode of the instruction that will be held next cycle. Registering
    // it alongside the state keeps every output a clean flop while still
    // reflecting the state being entered.
    logic [6:0]           w_op;
    logic [2:0]           w_f3;
    logic [6:0]           w_f7;
    logic                 w_legal;
    logic                 w_load;
    logic                 w_store;
    logic                 w_branch;
    logic                 w_src_imm;
    logic [ALUOP_W-1:0]   w_alu;
    logic [XLEN-1:0]      w_imm;
    logic                 w_busy;
    logic                 w_mem_last;

    assign w_op = w_nxt_ir[6:0];
    assign w_f3 = w_nxt_ir[14:12];
    assign w_f7 = w_nxt_ir[31:25];

    always_comb begin
        w_legal   = 1'b0;
        w_load    = 1'b0;
        w_store   = 1'b0;
        w_branch  = 1'b0;
        w_src_imm = 1'b0;
        w_alu     = c_ALU_ADD;
        w_imm     = {{(XLEN-12){w_nxt_ir[31]}}, w_nxt_ir[31:20]};
        case (w_op)
            c_OP_R: begin
                w_legal = (w_f7 == 7'b0000000);
                case (w_f3)
                    3'b000: begin
                        if (w_f7 == 7'b0100000) begin
                            w_legal = 1'b1;
                            w_alu   = c_ALU_SUB;
                        end
                    end
                    3'b111:  w_alu = c_ALU_AND;
                    3'b110:  w_alu = c_ALU_OR;
                    3'b100:  w_alu = c_ALU_XOR;
                    3'b010:  w_alu = c_ALU_SLT;
                    default: w_legal = 1'b0;
                endcase
            end
            c_OP_I: begin
                w_legal   = 1'b1;
                w_src_imm = 1'b1;
                case (w_f3)
                    3'b000:  w_alu = c_ALU_ADD;
                    3'b111:  w_alu = c_ALU_AND;
                    3'b110:  w_alu = c_ALU_OR;
                    3'b100:  w_alu = c_ALU_XOR;
                    3'b010:  w_alu = c_ALU_SLT;
                    default: w_legal = 1'b0;
                endcase
            end
            c_OP_LOAD: begin
                w_legal   = (w_f3 == 3'b010);
                w_load    = w_legal;
                w_src_imm = 1'b1;
            end
            c_OP_STORE: begin
                w_legal   = (w_f3 == 3'b010);
                w_store   = w_legal;
                w_src_imm = 1'b1;
                w_imm     = {{(XLEN-12){w_nxt_ir[31]}}, w_nxt_ir[31:25], w_nxt_ir[11:7]};
            end
`ifdef BRANCH_EN
            c_OP_BRANCH: begin
                w_legal  = (w_f3[2:1] == 2'b00);
                w_branch = w_legal;
                w_alu    = c_ALU_SUB;
                w_imm    = {{(XLEN-13){w_nxt_ir[31]}}, w_nxt_ir[31], w_nxt_ir[7],
                            w_nxt_ir[30:25], w_nxt_ir[11:8], 1'b0};
            end
`endif
            default: w_legal = 1'b0;
        endcase
    end

    // Next-state: transitions use the registered class flags, which describe
    // r_ir because they were decoded from it on the accepting edge.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_ir      = r_ir;
        w_nxt_mem_cnt = r_mem_cnt;
        case (r_state)
            S_IDLE: begin
                if (instr_valid && instr_ready) begin
                    w_nxt_state = S_DECODE;
                    w_nxt_ir    = instr;
                end
            end
            S_DECODE: w_nxt_state = r_legal ? S_EXEC : S_IDLE;
            S_EXEC: begin
                if (r_load || r_store) begin
                    w_nxt_state   = S_MEM;
                    w_nxt_mem_cnt = '0;
                end else if (r_branch) begin
                    w_nxt_state = S_IDLE;
                end else begin
                    w_nxt_state = S_WB;
                end
            end
            S_MEM: begin
                if (r_mem_cnt == c_MEM_LAST) begin
                    w_nxt_state = r_load ? S_WB : S_IDLE;
                end else begin
                    w_nxt_mem_cnt = r_mem_cnt + 1'b1;
                end
            end
            S_WB:    w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    assign w_busy     = (w_nxt_state != S_IDLE);
    assign w_mem_last = (w_nxt_mem_cnt == c_MEM_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_ir           <= '0;
            r_mem_cnt      <= '0;
            r_legal        <= 1'b0;
            r_load         <= 1'b0;
            r_store        <= 1'b0;
            r_branch       <= 1'b0;
            instr_ready    <= 1'b1;
            reg1_addr      <= '0;
            reg2_addr      <= '0;
            write_reg_addr <= '0;
            alu_op         <= '0;
            alu_src_imm    <= 1'b0;
            imm_out        <= '0;
            reg_we         <= 1'b0;
            mem_re         <= 1'b0;
            mem_we         <= 1'b0;
            mem_to_reg     <= 1'b0;
            done           <= 1'b0;
            illegal        <= 1'b0;
            retired_cnt    <= '0;
        end else begin
            r_state        <= w_nxt_state;
            r_ir           <= w_nxt_ir;
            r_mem_cnt      <= w_nxt_mem_cnt;
            r_legal        <= w_legal;
            r_load         <= w_load;
            r_store        <= w_store;
            r_branch       <= w_branch;
            instr_ready    <= !w_busy;
            reg1_addr      <= w_busy ? RADDR_W'(w_nxt_ir[19:15]) : '0;
            reg2_addr      <= w_busy ? RADDR_W'(w_nxt_ir[24:20]) : '0;
            write_reg_addr <= w_busy ? RADDR_W'(w_nxt_ir[11:7])  : '0;
            alu_op         <= w_busy ? w_alu : '0;
            alu_src_imm    <= w_busy & w_src_imm;
            imm_out        <= w_busy ? w_imm : '0;
            // x0 is hard-wired: its write is suppressed, completion is not.
            reg_we         <= (w_nxt_state == S_WB) && (w_nxt_ir[11:7] != 5'd0);
            mem_re         <= (w_nxt_state == S_MEM) && w_load;
            mem_we         <= (w_nxt_state == S_MEM) && w_store && (w_nxt_mem_cnt == '0);
            mem_to_reg     <= ((w_nxt_state == S_MEM) || (w_nxt_state == S_WB)) && w_load;
            done           <= (w_nxt_state == S_WB)
                           || ((w_nxt_state == S_MEM) && w_store && w_mem_last)
                           || ((w_nxt_state == S_EXEC) && w_branch);
            illegal        <= (w_nxt_state == S_DECODE) && !w_legal;
            // done is high during the completing cycle, so the count steps
            // on the edge that ends it.
            retired_cnt    <= retired_cnt + CNT_W'(done);
        end
    end

`ifdef BRANCH_EN
    logic r_bne;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bne <= 1'b0;
        end else begin
            r_bne <= w_f3[0];
        end
    end

    // zero_flag is produced by the ALU during EXEC itself, so this decision
    // is taken combinationally from the registered state.
    assign branch_taken = (r_state == S_EXEC) && r_branch && (r_bne ? !zero_flag : zero_flag);
`else
    logic w_unused_zero;
    assign w_unused_zero = zero_flag;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl_fsm
// Description : Scoreboard bench for multicycle_ctrl_fsm. Directed
//               instructions push hand-computed expectations; a monitor pops
//               and compares on every done/illegal pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

    localparam int MEM_LAT = 3;
    localparam int CNT_W   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        zero_flag;
    logic [4:0]  reg1_addr, reg2_addr, write_reg_addr;
    logic [2:0]  alu_op;
    logic        alu_src_imm;
    logic [31:0] imm_out;
    logic        reg_we, mem_re, mem_we, mem_to_reg, done, illegal;
    logic [CNT_W-1:0] retired_cnt;
`ifdef BRANCH_EN
    logic        branch_taken;
`endif

    multicycle_ctrl_fsm #(
        .XLEN(32), .RADDR_W(5), .ALUOP_W(3), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .zero_flag(zero_flag),
        .reg1_addr(reg1_addr), .reg2_addr(reg2_addr), .write_reg_addr(write_reg_addr),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm_out(imm_out),
        .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .mem_to_reg(mem_to_reg),
        .done(done), .illegal(illegal),
`ifdef BRANCH_EN
        .branch_taken(branch_taken),
`endif
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ill;
        int          lat;
        int          rwe;
        int          wr;
        bit          m2r;
        int          we_off;
        int          re_n;
        int          alu;
        bit          src;
        int          r1;
        int          r2;
        bit          chk_imm;
        logic [31:0] imm;
        int          cnt;
        int          br;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   mcnt   = 0;
    int   cyc    = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_done(int lat, int rwe, int wr, bit m2r, int we_off, int re_n,
                                     int alu, bit src, int r1, int r2, bit ci,
                                     logic [31:0] imm, int br);
        exp_t e;
        e.ill = 1'b0; e.lat = lat; e.rwe = rwe; e.wr = wr; e.m2r = m2r;
        e.we_off = we_off; e.re_n = re_n; e.alu = alu; e.src = src;
        e.r1 = r1; e.r2 = r2; e.chk_imm = ci; e.imm = imm; e.br = br;
        e.cnt = mcnt;
        mcnt = (mcnt + 1) % (1 << CNT_W);
        return e;
    endfunction

    function automatic exp_t mk_ill();
        exp_t e;
        e = mk_done(1, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 32'd0, 0);
        e.ill = 1'b1;
        e.cnt = (mcnt + (1 << CNT_W) - 1) % (1 << CNT_W);
        mcnt  = e.cnt;
        return e;
    endfunction

    // ---------------- monitor ----------------
    int t_acc = 0, we_off = -1, re_n = 0, rwe_n = 0, bt_n = 0;
    bit chk_rdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (chk_rdy) begin
                chk("ready_after_end", instr_ready, 1);
                chk_rdy = 0;
            end
            if (instr_valid && instr_ready) begin
                t_acc = cyc; we_off = -1; re_n = 0; rwe_n = 0; bt_n = 0;
            end else begin
                if (mem_we) we_off = (we_off == -1) ? (cyc - t_acc) : -2;
                if (mem_re) re_n++;
                if (reg_we) rwe_n++;
`ifdef BRANCH_EN
                if (branch_taken) bt_n++;
`endif
                if (done || illegal) begin
                    chk_rdy = 1;
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_event: done=%0b illegal=%0b with empty queue", done, illegal);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("illegal", illegal, e.ill);
                        chk("done", done, !e.ill);
                        chk("latency", cyc - t_acc, e.lat);
                        chk("retired_cnt", retired_cnt, e.cnt);
                        if (!e.ill) begin
                            chk("reg_we_cycles", rwe_n, e.rwe);
                            chk("write_reg_addr", write_reg_addr, e.wr);
                            chk("mem_to_reg", mem_to_reg, e.m2r);
                            chk("mem_we_offset", we_off, e.we_off);
                            chk("mem_re_cycles", re_n, e.re_n);
                            chk("alu_op", alu_op, e.alu);
                            chk("alu_src_imm", alu_src_imm, e.src);
                            chk("reg1_addr", reg1_addr, e.r1);
                            chk("reg2_addr", reg2_addr, e.r2);
                            if (e.chk_imm) chk("imm_out", imm_out, e.imm);
`ifdef BRANCH_EN
                            chk("branch_taken_cycles", bt_n, e.br);
`endif
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!instr_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: instr_ready=0 expected 1 within 60 cycles");
        end
    endtask

    task automatic issue(input logic [31:0] ins, input exp_t e);
        wait_ready();
        q.push_back(e);
        instr = ins; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0; instr = '0;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_outputs"}, {reg1_addr, reg2_addr, write_reg_addr, alu_op, alu_src_imm,
             reg_we, mem_re, mem_we, mem_to_reg, done, illegal} | longint'(imm_out), 0);
        chk({nm, "_ready"}, instr_ready, 1);
        chk({nm, "_cnt"}, retired_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = '0; zero_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b0;

        issue(32'h00800913, mk_done(3, 1, 18, 0, -1, 0, 0, 1, 0, 8, 1, 32'd8, 0));          // addi x18,x0,8
        issue(32'h012020A3, mk_done(2+MEM_LAT, 0, 1, 0, 3, 0, 0, 1, 0, 18, 1, 32'd1, 0));  // sw x18,1(x0)
        issue(32'h00102E03, mk_done(3+MEM_LAT, 1, 28, 1, -1, MEM_LAT, 0, 1, 0, 1, 1, 32'd1, 0)); // lw x28,1(x0)
        issue(32'h01DE0F33, mk_done(3, 1, 30, 0, -1, 0, 0, 0, 28, 29, 0, 32'd0, 0));      // add x30,x28,x29
        issue(32'h00000000, mk_ill());
        issue(32'h41DE7F33, mk_ill());                                                     // AND with funct7=0100000
        issue(32'h00500013, mk_done(3, 0, 0, 0, -1, 0, 0, 1, 0, 5, 1, 32'd5, 0));          // addi x0,x0,5
        issue(32'h0020A1B3, mk_done(3, 1, 3, 0, -1, 0, 5, 0, 1, 2, 0, 32'd0, 0));          // slt x3,x1,x2
        issue(32'h407302B3, mk_done(3, 1, 5, 0, -1, 0, 1, 0, 6, 7, 0, 32'd0, 0));          // sub x5,x6,x7
        issue(32'hFFF24213, mk_done(3, 1, 4, 0, -1, 0, 4, 1, 4, 31, 1, 32'hFFFFFFFF, 0));  // xori x4,x4,-1
`ifdef BRANCH_EN
        zero_flag = 1'b1;
        issue(32'h00208463, mk_done(2, 0, 8, 0, -1, 0, 1, 0, 1, 2, 1, 32'd8, 1));          // beq taken
        wait_ready();
        zero_flag = 1'b0;
        issue(32'h00208463, mk_done(2, 0, 8, 0, -1, 0, 1, 0, 1, 2, 1, 32'd8, 0));          // beq not taken
        wait_ready();
`else
        issue(32'h00208463, mk_ill());                                                     // branch opcode unsupported
`endif
        issue(32'h003160B3, mk_done(3, 1, 1, 0, -1, 0, 3, 0, 2, 3, 0, 32'd0, 0));          // or x1,x2,x3

        // Reset held two cycles in the MEM phase of a load; nothing is queued
        // because the instruction must never complete.
        wait_ready();
        instr = 32'h00102E03; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0; instr = '0;
        begin
            int n = 0;
            while (!mem_re && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("reached_mem_before_reset", mem_re, 1);
        end
        chk("cnt_nonzero_before_reset", retired_cnt, mcnt);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("mid_load_reset");
        reset = 1'b0;
        mcnt  = 0;
        @(posedge clk); #1;
        chk_idle("after_reset");

        issue(32'h00800913, mk_done(3, 1, 18, 0, -1, 0, 0, 1, 0, 8, 1, 32'd8, 0));
        wait_ready();
        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        chk("final_cnt", retired_cnt, mcnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
